// File: rtl/i2s_playback_ctrl.sv
// i2s_playback_ctrl: sequences FX2LP slave-FIFO words into i2s_master.
// Handles prefill, underrun muting with frame realign, and gated config.
module i2s_playback_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             play_en,
    input  logic             cfg_load,
    input  logic [1:0]       cfg_word_size,
    input  logic [3:0]       cfg_sck_div,
    input  logic [15:0]      fifo_data,
    input  logic             half_n,
    input  logic             ef_n,
    output logic             slrd_n,
    input  logic             data_req,
    output logic [15:0]      data_out,
    output logic [1:0]       word_size,
    output logic [3:0]       sck_div,
    output logic             i2s_rst_n,
    output logic             playing,
    output logic             underrun,
    input  logic             underrun_clr,
    output logic [CNT_W-1:0] urun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN,
        S_MUTE,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             data_req_q;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [15:0]      data_q, data_d;
    logic             slrd_q, slrd_d;
    logic [1:0]       ws_q, ws_d;
    logic [3:0]       div_q, div_d;
    logic [1:0]       pend_ws_q, pend_ws_d;
    logic [3:0]       pend_div_q, pend_div_d;
    logic             cfg_pend_q, cfg_pend_d;
    logic             i2s_rst_q, i2s_rst_d;
    logic             playing_q, playing_d;
    logic             urun_q, urun_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req;
    logic             urun_evt;
    logic [1:0]       wcnt_max;
    logic [1:0]       wcnt_nxt;
    logic [1:0]       cfg_ws_in;

    assign req       = data_req & ~data_req_q;
    assign wcnt_max  = (ws_q == 2'd0) ? 2'd1 : 2'd3;
    assign wcnt_nxt  = (wcnt_q == wcnt_max) ? 2'd0 : wcnt_q + 2'd1;
    assign cfg_ws_in = (cfg_word_size == 2'd3) ? 2'd2 : cfg_word_size;

    // Next-state logic for the sequencer, config latch and underrun tracking
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        data_d     = data_q;
        slrd_d     = 1'b1;
        ws_d       = ws_q;
        div_d      = div_q;
        pend_ws_d  = pend_ws_q;
        pend_div_d = pend_div_q;
        cfg_pend_d = cfg_pend_q;
        i2s_rst_d  = i2s_rst_q;
        playing_d  = playing_q;
        urun_d     = urun_q;
        cnt_d      = cnt_q;
        urun_evt   = 1'b0;

        if (cfg_load) begin
            pend_ws_d  = cfg_ws_in;
            pend_div_d = cfg_sck_div;
            cfg_pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                wcnt_d    = 2'd0;
                i2s_rst_d = 1'b0;
                playing_d = 1'b0;
                if (play_en) begin
                    if (cfg_load) begin
                        ws_d       = cfg_ws_in;
                        div_d      = cfg_sck_div;
                        cfg_pend_d = 1'b0;
                    end else if (cfg_pend_q) begin
                        ws_d       = pend_ws_q;
                        div_d      = pend_div_q;
                        cfg_pend_d = 1'b0;
                    end
                    state_d = S_PREFILL;
                end
            end
            S_PREFILL: begin
                wcnt_d = 2'd0;
                if (!play_en) begin
                    state_d = S_IDLE;
                end else if (!half_n) begin
                    state_d   = S_RUN;
                    i2s_rst_d = 1'b1;
                    playing_d = 1'b1;
                end
            end
            S_RUN: begin
                if (req) begin
                    wcnt_d = wcnt_nxt;
                    if (ef_n) begin
                        data_d = fifo_data;
                        slrd_d = 1'b0;
                    end else begin
                        data_d    = 16'd0;
                        urun_evt  = 1'b1;
                        state_d   = S_MUTE;
                        playing_d = 1'b0;
                    end
                end
                if (!play_en) begin
                    state_d   = S_STOP;
                    playing_d = 1'b0;
                end
            end
            S_MUTE: begin
                if (req) begin
                    wcnt_d = wcnt_nxt;
                    if (play_en && wcnt_q == 2'd0 && !half_n && ef_n) begin
                        data_d    = fifo_data;
                        slrd_d    = 1'b0;
                        state_d   = S_RUN;
                        playing_d = 1'b1;
                    end else begin
                        data_d = 16'd0;
                    end
                end
                if (!play_en) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (req) begin
                    data_d = 16'd0;
                    wcnt_d = wcnt_nxt;
                    if (wcnt_q == 2'd0) begin
                        state_d   = S_IDLE;
                        wcnt_d    = 2'd0;
                        i2s_rst_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new underrun wins over a simultaneous clear
        if (urun_evt) begin
            urun_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (underrun_clr) begin
            urun_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_req_q <= 1'b0;
            wcnt_q     <= 2'd0;
            data_q     <= 16'd0;
            slrd_q     <= 1'b1;
            ws_q       <= 2'd0;
            div_q      <= 4'd0;
            pend_ws_q  <= 2'd0;
            pend_div_q <= 4'd0;
            cfg_pend_q <= 1'b0;
            i2s_rst_q  <= 1'b0;
            playing_q  <= 1'b0;
            urun_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            data_req_q <= data_req;
            wcnt_q     <= wcnt_d;
            data_q     <= data_d;
            slrd_q     <= slrd_d;
            ws_q       <= ws_d;
            div_q      <= div_d;
            pend_ws_q  <= pend_ws_d;
            pend_div_q <= pend_div_d;
            cfg_pend_q <= cfg_pend_d;
            i2s_rst_q  <= i2s_rst_d;
            playing_q  <= playing_d;
            urun_q     <= urun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign slrd_n    = slrd_q;
    assign data_out  = data_q;
    assign word_size = ws_q;
    assign sck_div   = div_q;
    assign i2s_rst_n = i2s_rst_q;
    assign playing   = playing_q;
    assign underrun  = urun_q;
    assign urun_cnt  = cnt_q;

endmodule
